// File: rtl/conv_pkg.sv
// Shared types, constants and the pixel scaling helper for the convolution engine.
package conv_pkg;

  // nop_in level that marks a pipeline bubble
  localparam logic NOP_ACTIVE = 1'b1;

  localparam int unsigned CONV_ACC_W = 40;
  localparam int unsigned CONV_OUT_W = 16;

  typedef logic signed [CONV_ACC_W-1:0] acc_t;
  typedef logic signed [CONV_OUT_W-1:0] pixel_t;

  // Arithmetic right shift (floor, no rounding), then clamp to the signed pixel range.
  function automatic pixel_t sat_shift(input acc_t value, input int unsigned shift);
    acc_t                        shifted;
    logic [CONV_ACC_W-CONV_OUT_W:0] top_bits;
    shifted  = value >>> shift;
    top_bits = shifted[CONV_ACC_W-1:CONV_OUT_W-1];
    // In range when every bit above the pixel MSB matches the sign
    if ((&top_bits) || !(|top_bits)) begin
      return shifted[CONV_OUT_W-1:0];
    end else if (shifted[CONV_ACC_W-1]) begin
      return {1'b1, {(CONV_OUT_W-1){1'b0}}};
    end else begin
      return {1'b0, {(CONV_OUT_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/conv_sync_fifo.sv
// Small first-word-fall-through FIFO; the head entry is always on pop_data.
module conv_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  // A push into a full FIFO is only accepted when the head leaves on the same edge
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Occupancy bookkeeping for simultaneous push/pop
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage; cleared on reset so the head reads zero while empty
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// Sums one kernel window of MAC results into a scaled, saturated pixel and queues it.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ACC_W      = CONV_ACC_W,
  parameter int unsigned OUT_W      = CONV_OUT_W,
  parameter int unsigned TERMS      = 9,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic [DATA_W-1:0]         sum_in,
  input  logic                      nop_in,
  input  logic                      frame_start,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(TERMS)-1:0]  term_count,
  output logic                      overflow_err
);

  localparam int unsigned CNT_W = $clog2(TERMS);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] base_acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0]        base_cnt;
  logic                    term_valid;
  logic                    final_term;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [OUT_W-1:0]        pixel;
  logic                    drop;

  assign sum_ext    = {{(ACC_W-DATA_W){sum_in[DATA_W-1]}}, sum_in};
  assign term_valid = (nop_in != NOP_ACTIVE);
  // frame_start discards the partial window; a same-cycle term then opens the new one
  assign base_acc   = frame_start ? '0 : acc_q;
  assign base_cnt   = frame_start ? '0 : cnt_q;
  assign final_term = term_valid && (base_cnt == CNT_W'(TERMS - 1));

  assign pixel = OUT_W'(sat_shift(acc_t'(res_q), SHIFT));
  // Full implies out_valid, so a drop only needs the consumer to be stalled
  assign drop  = pend_q && fifo_full && !out_ready;

  // Window accumulation, result capture and sticky overflow next-state
  always_comb begin
    acc_d   = base_acc;
    cnt_d   = base_cnt;
    res_d   = res_q;
    pend_d  = 1'b0;
    ovf_d   = frame_start ? 1'b0 : ovf_q;
    acc_sum = base_acc;
    if (term_valid) begin
      acc_sum = base_acc + sum_ext;
      if (final_term) begin
        res_d  = acc_sum;
        pend_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = base_cnt + CNT_W'(1);
      end
    end
    if (drop) ovf_d = 1'b1;
  end

  // Window state registers
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  conv_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .aclr      (aclr),
    .push      (pend_q),
    .push_data (pixel),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign term_count   = cnt_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator with hand-computed pixel values.
module tb_conv_accumulator;

  logic        clk;
  logic        aclr;
  logic [31:0] sum_in;
  logic        nop_in;
  logic        frame_start;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  term_count;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  conv_accumulator dut (
    .clk          (clk),
    .aclr         (aclr),
    .sum_in       (sum_in),
    .nop_in       (nop_in),
    .frame_start  (frame_start),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .term_count   (term_count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic term(input logic [31:0] v);
    nop_in = 1'b0;
    sum_in = v;
    tick();
    nop_in = 1'b1;
    sum_in = 'x;
  endtask

  task automatic window(input logic [31:0] v);
    for (int i = 0; i < 9; i++) term(v);
  endtask

  // Called right after the final term with out_ready=1: one pixel for exactly one cycle
  task automatic expect_pixel(input string tag, input logic [15:0] exp);
    tick();
    check({tag, "_valid"}, 40'(out_valid), 40'd1);
    check({tag, "_data"}, 40'(out_data), 40'(exp));
    tick();
    check({tag, "_gone"}, 40'(out_valid), 40'd0);
  endtask

  initial begin
    aclr        = 1'b1;
    nop_in      = 1'b1;
    sum_in      = '0;
    frame_start = 1'b0;
    out_ready   = 1'b1;
    #12;
    check("rst_valid", 40'(out_valid), 40'd0);
    check("rst_data", 40'(out_data), 40'd0);
    check("rst_count", 40'(term_count), 40'd0);
    check("rst_ovf", 40'(overflow_err), 40'd0);
    aclr = 1'b0;
    tick();

    // Basic window: 9 x 256 = 2304, >>> 8 = 9
    for (int i = 0; i < 3; i++) term(32'd256);
    check("win_count3", 40'(term_count), 40'd3);
    for (int i = 0; i < 6; i++) term(32'd256);
    check("win_not_yet", 40'(out_valid), 40'd0);
    check("win_count0", 40'(term_count), 40'd0);
    expect_pixel("win", 16'd9);

    // Bubbles between terms, positive saturation: 9 * 2^20 >>> 8 = 36864
    for (int i = 0; i < 9; i++) begin
      term(32'h0010_0000);
      if (i < 8) tick();
      if (i == 4) check("bubble_hold", 40'(term_count), 40'd5);
    end
    expect_pixel("sat_pos", 16'h7FFF);
    window(32'hFFF0_0000);
    expect_pixel("sat_neg", 16'h8000);
    // -9 >>> 8 floors to -1
    window(32'hFFFF_FFFF);
    expect_pixel("trunc", 16'hFFFF);

    // Back-pressure: five pixels 9,18,27,36,45 into a 4-deep FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) window(32'(256 * k));
    tick();
    check("bp_ovf", 40'(overflow_err), 40'd1);
    check("bp_valid", 40'(out_valid), 40'd1);
    check("bp_head", 40'(out_data), 40'd9);
    tick();
    check("bp_hold", 40'(out_data), 40'd9);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp_drain", 40'(out_data), 40'(9 * k));
      tick();
    end
    check("bp_empty", 40'(out_valid), 40'd0);
    check("bp_ovf_sticky", 40'(overflow_err), 40'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fs_clr_ovf", 40'(overflow_err), 40'd0);

    // Full FIFO with a pop on the push edge: no drop
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) window(32'(256 * k));
    out_ready = 1'b1;
    tick();
    check("fp_ovf", 40'(overflow_err), 40'd0);
    for (int k = 2; k <= 5; k++) begin
      check("fp_drain", 40'(out_data), 40'(9 * k));
      tick();
    end
    check("fp_empty", 40'(out_valid), 40'd0);

    // frame_start with a term: old 5 terms discarded, 512 + 8 x 256 = 2560 -> 10
    for (int i = 0; i < 5; i++) term(32'd256);
    check("fs_count5", 40'(term_count), 40'd5);
    frame_start = 1'b1;
    term(32'd512);
    frame_start = 1'b0;
    check("fs_count1", 40'(term_count), 40'd1);
    for (int i = 0; i < 8; i++) term(32'd256);
    expect_pixel("fs_pix", 16'd10);

    // Asynchronous reset while a pixel is pending
    window(32'd256);
    #2;
    aclr = 1'b1;
    #1;
    check("ar_valid", 40'(out_valid), 40'd0);
    check("ar_count", 40'(term_count), 40'd0);
    aclr = 1'b0;
    tick();
    tick();
    check("ar_no_pixel", 40'(out_valid), 40'd0);
    window(32'd512);
    expect_pixel("ar_after", 16'd18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
